// File: rtl/channel_emu_pkg.sv
// Shared definitions for the IQ loopback channel emulator: rotation
// encodings, LFSR polynomial, default seed and a generic clamp helper.
package channel_emu_pkg;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_P90 = 2'd1,
    ROT_180 = 2'd2,
    ROT_M90 = 2'd3
  } rot_e;

  // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Clamp a signed value into the range of a w-bit two's complement number
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                  input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/channel_emu_lfsr.sv
// Noise source for the channel emulator: a 16-bit Galois LFSR stepped once
// per sample strobe, with the low byte feeding I and the high byte feeding Q.
// Each byte is scaled down to k bits and re-centred around zero.
module channel_emu_lfsr
  import channel_emu_pkg::*;
#(
  parameter int          NOISE_W = 6,
  parameter logic [15:0] SEED    = DEFAULT_SEED
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic [3:0]        i_amp,
  output logic signed [8:0] o_noise_I,
  output logic signed [8:0] o_noise_Q
);

  logic [15:0]       r_lfsr;
  logic [3:0]        w_k;
  logic [8:0]        w_half;
  logic signed [8:0] w_noise [2];

  // Advance the LFSR one step per sample strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else if (i_ce) begin
      r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
    end
  end

  // Requested noise width is limited to what the build allows
  assign w_k    = (i_amp > 4'(NOISE_W)) ? 4'(NOISE_W) : i_amp;
  // Centring offset 2^(k-1); k=0 shifts the byte out entirely and needs none
  assign w_half = (w_k == 4'd0) ? 9'd0 : (9'd1 << (w_k - 4'd1));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [8:0] w_byte;
      assign w_byte      = {1'b0, r_lfsr[8*gi +: 8]};
      assign w_noise[gi] = $signed((w_byte >> (4'd8 - w_k)) - w_half);
    end
  endgenerate

  assign o_noise_I = w_noise[0];
  assign o_noise_Q = w_noise[1];

endmodule

// File: rtl/iq_channel_emu.sv
// Baseband loopback channel model between Tx DAC and Rx ADC samples.
// Pipeline per sample strobe: rotation -> gain/noise/offset/clamp ->
// programmable delay line -> registered ADC outputs.
// Optional build macro CHANNEL_EMU_SAT_CNT_EN adds a saturating counter of
// clipped samples on sat_count; without it sat_count is constant zero.
module iq_channel_emu
  import channel_emu_pkg::*;
#(
  parameter int          DATA_W      = 12,
  parameter int          DELAY_DEPTH = 16,
  parameter int          NOISE_W     = 6,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                           clk_32M768,
  input  logic                           rst_32M768,
  input  logic                           ce,
  input  logic signed [DATA_W-1:0]       din_I,
  input  logic signed [DATA_W-1:0]       din_Q,
  input  logic                           din_valid,
  input  logic [1:0]                     ROT_CTRL,
  input  logic [3:0]                     GAIN,
  input  logic [3:0]                     NOISE_AMP,
  input  logic signed [7:0]              DC_OFFSET,
  input  logic [$clog2(DELAY_DEPTH)-1:0] DELAY_CNT,
  input  logic                           sat_clr,
  output logic signed [DATA_W-1:0]       ADC_I,
  output logic signed [DATA_W-1:0]       ADC_Q,
  output logic                           ADC_valid,
  output logic                           sat_flag,
  output logic [15:0]                    sat_count
);

  localparam int          AW       = $clog2(DELAY_DEPTH);
  // Working width for gain, noise and offset: wide enough that nothing wraps
  localparam int          SW       = DATA_W + 7;
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0) ? DEFAULT_SEED : LFSR_SEED;

  // Negation that maps the most negative code to the most positive one
  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] min_v;
    min_v = {1'b1, {(DATA_W-1){1'b0}}};
    return (x == min_v) ? ~x : -x;
  endfunction

  // Channel index 0 carries I, index 1 carries Q throughout
  logic signed [DATA_W-1:0] w_rot   [2];
  logic signed [DATA_W-1:0] r_rot   [2];
  logic                     r_v1;
  logic signed [DATA_W-1:0] w_res   [2];
  logic                     w_clip_ch [2];
  logic signed [DATA_W-1:0] r_s2    [2];
  logic                     r_v2;
  logic                     w_clip;
  logic signed [8:0]        w_noise [2];
  logic signed [SW-1:0]     w_gain_ext;

  logic [2*DATA_W-1:0]      r_mem [DELAY_DEPTH];
  logic [DELAY_DEPTH-1:0]   r_mem_v;
  logic [AW-1:0]            r_wp;
  logic [AW-1:0]            w_rd;
  logic                     w_sel_v;
  logic [2*DATA_W-1:0]      w_sel_data;

  logic signed [DATA_W-1:0] r_adc_I;
  logic signed [DATA_W-1:0] r_adc_Q;
  logic                     r_adc_valid;
  logic                     r_sat_flag;

  channel_emu_lfsr #(
    .NOISE_W (NOISE_W),
    .SEED    (SEED_EFF)
  ) u_lfsr (
    .i_clk     (clk_32M768),
    .i_rst     (rst_32M768),
    .i_ce      (ce),
    .i_amp     (NOISE_AMP),
    .o_noise_I (w_noise[0]),
    .o_noise_Q (w_noise[1])
  );

  // Quarter-turn rotation of the incoming Tx sample
  always_comb begin
    w_rot[0] = din_I;
    w_rot[1] = din_Q;
    case (ROT_CTRL)
      ROT_P90: begin w_rot[0] = neg_sat(din_Q); w_rot[1] = din_I;          end
      ROT_180: begin w_rot[0] = neg_sat(din_I); w_rot[1] = neg_sat(din_Q); end
      ROT_M90: begin w_rot[0] = din_Q;          w_rot[1] = neg_sat(din_I); end
      default: begin w_rot[0] = din_I;          w_rot[1] = din_Q;          end
    endcase
  end

  // Stage 1: register the rotated sample and its valid bit
  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      r_rot[0] <= '0;
      r_rot[1] <= '0;
      r_v1     <= 1'b0;
    end else if (ce) begin
      r_rot[0] <= w_rot[0];
      r_rot[1] <= w_rot[1];
      r_v1     <= din_valid;
    end
  end

  assign w_gain_ext = SW'($signed({1'b0, GAIN}));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_arith
      logic signed [SW-1:0] w_prod;
      logic signed [SW-1:0] w_sum;
      logic signed [31:0]   w_sum32;
      logic signed [31:0]   w_sat32;
      // Arithmetic shift floors, so the gain truncates toward -inf
      assign w_prod        = SW'(r_rot[gi]) * w_gain_ext;
      assign w_sum         = (w_prod >>> 2) + SW'(w_noise[gi]) + SW'(DC_OFFSET);
      assign w_sum32       = 32'(w_sum);
      assign w_sat32       = saturate(w_sum32, DATA_W);
      assign w_res[gi]     = w_sat32[DATA_W-1:0];
      assign w_clip_ch[gi] = (w_sat32 != w_sum32);
    end
  endgenerate

  // One clip event per valid sample, however many channels clamp
  assign w_clip = ce & r_v1 & (w_clip_ch[0] | w_clip_ch[1]);

  // Stage 2: register the scaled, noisy, offset and clamped sample
  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      r_s2[0] <= '0;
      r_s2[1] <= '0;
      r_v2    <= 1'b0;
    end else if (ce) begin
      r_s2[0] <= w_res[0];
      r_s2[1] <= w_res[1];
      r_v2    <= r_v1;
    end
  end

  // Sticky clip flag; a clip in the same clock as a clear takes priority
  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      r_sat_flag <= 1'b0;
    end else if (w_clip) begin
      r_sat_flag <= 1'b1;
    end else if (sat_clr) begin
      r_sat_flag <= 1'b0;
    end
  end

  // Delay-line sample storage, kept free of reset so it maps onto RAM
  always_ff @(posedge clk_32M768) begin
    if (ce) begin
      r_mem[r_wp] <= {r_s2[0], r_s2[1]};
    end
  end

  // Delay-line valid bits and write pointer, cleared so stale data never escapes
  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      r_mem_v <= '0;
      r_wp    <= '0;
    end else if (ce) begin
      r_mem_v[r_wp] <= r_v2;
      r_wp          <= r_wp + 1'b1;
    end
  end

  // Zero extra delay bypasses the buffer; otherwise read DELAY_CNT entries back
  always_comb begin
    w_rd       = r_wp - DELAY_CNT;
    w_sel_v    = r_v2;
    w_sel_data = {r_s2[0], r_s2[1]};
    if (DELAY_CNT != '0) begin
      w_sel_v    = r_mem_v[w_rd];
      w_sel_data = r_mem[w_rd];
    end
  end

  // Output register: invalid slots present as zero
  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      r_adc_I     <= '0;
      r_adc_Q     <= '0;
      r_adc_valid <= 1'b0;
    end else if (ce) begin
      r_adc_I     <= w_sel_v ? w_sel_data[2*DATA_W-1:DATA_W] : '0;
      r_adc_Q     <= w_sel_v ? w_sel_data[DATA_W-1:0]        : '0;
      r_adc_valid <= w_sel_v;
    end
  end

  assign ADC_I     = r_adc_I;
  assign ADC_Q     = r_adc_Q;
  assign ADC_valid = r_adc_valid;
  assign sat_flag  = r_sat_flag;

`ifdef CHANNEL_EMU_SAT_CNT_EN
  logic [15:0] r_sat_count;

  // Count clipped samples, sticking at full scale; only reset clears it
  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      r_sat_count <= '0;
    end else if (w_clip && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign sat_count = r_sat_count;
`else
  assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_iq_channel_emu.sv
// Scoreboard bench for iq_channel_emu. The driver computes each expected
// output from a per-tick history of inputs and configuration using plain
// arithmetic, pushes it into a queue, and a separate monitor pops and
// compares after every sample strobe.
module tb_iq_channel_emu;

  localparam int MAXT = 8192;

  typedef struct {
    int v;
    int i;
    int q;
    int flag;
    int cnt;
    int tick;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               ce = 1'b0;
  logic signed [11:0] din_I = '0;
  logic signed [11:0] din_Q = '0;
  logic               din_valid = 1'b0;
  logic [1:0]         ROT_CTRL = '0;
  logic [3:0]         GAIN = '0;
  logic [3:0]         NOISE_AMP = '0;
  logic signed [7:0]  DC_OFFSET = '0;
  logic [3:0]         DELAY_CNT = '0;
  logic               sat_clr = 1'b0;
  logic signed [11:0] ADC_I;
  logic signed [11:0] ADC_Q;
  logic               ADC_valid;
  logic               sat_flag;
  logic [15:0]        sat_count;

  iq_channel_emu dut (
    .clk_32M768 (clk),
    .rst_32M768 (rst),
    .ce         (ce),
    .din_I      (din_I),
    .din_Q      (din_Q),
    .din_valid  (din_valid),
    .ROT_CTRL   (ROT_CTRL),
    .GAIN       (GAIN),
    .NOISE_AMP  (NOISE_AMP),
    .DC_OFFSET  (DC_OFFSET),
    .DELAY_CNT  (DELAY_CNT),
    .sat_clr    (sat_clr),
    .ADC_I      (ADC_I),
    .ADC_Q      (ADC_Q),
    .ADC_valid  (ADC_valid),
    .sat_flag   (sat_flag),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: per-tick history since the last reset
  int m_i [MAXT];
  int m_q [MAXT];
  int m_v [MAXT];
  int m_rot [MAXT];
  int m_g [MAXT];
  int m_na [MAXT];
  int m_dc [MAXT];
  int m_lf [MAXT];
  int n = 0;
  int total_ticks = 0;
  int m_lfsr = 'hACE1;
  int m_flag = 0;
  int m_cnt = 0;
  int rot_c = 0, gain_c = 4, na_c = 0, dc_c = 0, dl_c = 0;
  exp_t exp_q[$];
  exp_t last_e;

  // Noise statistics gathered by the monitor
  bit collect = 1'b0;
  int st_cnt = 0, st_sum_i = 0, st_sum_q = 0, st_bad = 0, st_diff = 0;

  function automatic int neg_sat(input int x);
    return (x == -2048) ? 2047 : -x;
  endfunction

  function automatic int floor_div4(input int p);
    return (p >= 0) ? (p / 4) : -((-p + 3) / 4);
  endfunction

  function automatic int clamp12(input int x, output bit c);
    c = 1'b0;
    if (x > 2047) begin c = 1'b1; return 2047; end
    if (x < -2048) begin c = 1'b1; return -2048; end
    return x;
  endfunction

  // Full channel transform of one sample from the functional description
  function automatic void proc(input int di, input int dq, input int rot, input int gain,
                               input int na, input int dc, input int lf,
                               output int oi, output int oq, output bit clip);
    int a, b, k, ni, nq;
    bit ci, cq;
    case (rot)
      1: begin a = neg_sat(dq); b = di; end
      2: begin a = neg_sat(di); b = neg_sat(dq); end
      3: begin a = dq; b = neg_sat(di); end
      default: begin a = di; b = dq; end
    endcase
    k = (na > 6) ? 6 : na;
    ni = 0;
    nq = 0;
    if (k > 0) begin
      ni = ((lf & 255) >> (8 - k)) - (1 << (k - 1));
      nq = (((lf >> 8) & 255) >> (8 - k)) - (1 << (k - 1));
    end
    oi = clamp12(floor_div4(a * gain) + ni + dc, ci);
    oq = clamp12(floor_div4(b * gain) + nq + dc, cq);
    clip = ci | cq;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // One sample strobe: record stimulus, predict output, then clock ce=1 and ce=0
  task automatic tick(input int di, input int dq, input int dv, input int clr);
    int k, j, oi, oq;
    bit cl, cl2;
    exp_t e;
    k = n;
    m_i[k] = di; m_q[k] = dq; m_v[k] = dv; m_rot[k] = rot_c;
    m_g[k] = gain_c; m_na[k] = na_c; m_dc[k] = dc_c; m_lf[k] = m_lfsr;
    cl = 1'b0;
    if (k >= 1 && m_v[k-1] != 0)
      proc(m_i[k-1], m_q[k-1], m_rot[k-1], gain_c, na_c, dc_c, m_lfsr, oi, oq, cl);
    if (cl) m_flag = 1;
    else if (clr != 0) m_flag = 0;
`ifdef CHANNEL_EMU_SAT_CNT_EN
    if (cl && m_cnt < 65535) m_cnt++;
`endif
    j = k - 2 - dl_c;
    e.v = 0; e.i = 0; e.q = 0;
    if (j >= 0 && m_v[j] != 0) begin
      proc(m_i[j], m_q[j], m_rot[j], m_g[j+1], m_na[j+1], m_dc[j+1], m_lf[j+1], oi, oq, cl2);
      e.v = 1; e.i = oi; e.q = oq;
    end
    e.flag = m_flag;
    e.cnt = m_cnt;
    e.tick = total_ticks;
    exp_q.push_back(e);
    last_e = e;
    m_lfsr = ((m_lfsr & 1) != 0) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
    n++;
    total_ticks++;
    din_I = 12'(di); din_Q = 12'(dq); din_valid = (dv != 0);
    ROT_CTRL = 2'(rot_c); GAIN = 4'(gain_c); NOISE_AMP = 4'(na_c);
    DC_OFFSET = 8'(dc_c); DELAY_CNT = 4'(dl_c); sat_clr = (clr != 0);
    ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0;
    sat_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges, held three clocks
  task automatic do_reset();
    ce = 1'b0;
    sat_clr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("reset_adc_I", int'(ADC_I), 0);
    chk("reset_adc_Q", int'(ADC_Q), 0);
    chk("reset_valid_flag_cnt", int'({ADC_valid, sat_flag}) + int'(sat_count), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    m_lfsr = 'hACE1;
    m_flag = 0;
    m_cnt = 0;
  endtask

  // Clocks with ce low must leave every output untouched
  task automatic freeze();
    for (int c = 0; c < 4; c++) begin
      din_I = 12'($urandom);
      din_Q = 12'($urandom);
      din_valid = 1'b1;
      ce = 1'b0;
      @(posedge clk);
      #1;
      chk("freeze_I", int'(ADC_I), last_e.i);
      chk("freeze_valid", int'(ADC_valid), last_e.v);
      @(negedge clk);
    end
  endtask

  // sat_clr on a clock without ce still clears the flag
  task automatic clr_offce();
    chk("sat_flag_before_clr", int'(sat_flag), 1);
    sat_clr = 1'b1;
    ce = 1'b0;
    @(posedge clk);
    #1;
    m_flag = 0;
    chk("sat_clr_without_ce", int'(sat_flag), 0);
    @(negedge clk);
    sat_clr = 1'b0;
  endtask

  // Monitor: every strobe presents an output slot, compared against the queue
  exp_t me;
  int   mai, maq;
  always @(posedge clk) begin
    if (ce && !rst) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got an output with no expected entry");
      end else begin
        me = exp_q.pop_front();
        mai = int'(ADC_I);
        maq = int'(ADC_Q);
        if (mai != me.i || maq != me.q || int'(ADC_valid) != me.v ||
            int'(sat_flag) != me.flag || int'(sat_count) != me.cnt) begin
          errors++;
          $display("FAIL adc_tick%0d: got v=%0d I=%0d Q=%0d flag=%0d cnt=%0d, expected v=%0d I=%0d Q=%0d flag=%0d cnt=%0d",
                   me.tick, ADC_valid, mai, maq, sat_flag, sat_count,
                   me.v, me.i, me.q, me.flag, me.cnt);
        end
        if (collect && ADC_valid) begin
          st_cnt++;
          st_sum_i += mai;
          st_sum_q += maq;
          if (mai < -16 || mai > 15 || maq < -16 || maq > 15) st_bad++;
          if (mai != maq) st_diff++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Passthrough and bypass latency
    rot_c = 0; gain_c = 4; na_c = 0; dc_c = 0; dl_c = 0;
    tick(100, -200, 1, 0);
    repeat (3) tick(0, 0, 0, 0);

    // Rotation with negation of the most negative code
    rot_c = 3; gain_c = 3;
    tick(-2048, 400, 1, 0);
    rot_c = 1;
    tick(-2048, 400, 1, 0);
    repeat (3) tick(0, 0, 0, 0);

    // Saturation, flag clear, clip-vs-clear priority
    rot_c = 0; gain_c = 15; dc_c = 127;
    tick(2000, 0, 1, 0);
    repeat (3) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(2000, 0, 1, 0);
    tick(0, 0, 0, 1);
    repeat (2) tick(0, 0, 0, 0);
    clr_offce();
    tick(0, 0, 0, 0);

    // Randomized configuration and data, including delay changes mid-stream
    for (int t = 0; t < 300; t++) begin
      if (t % 40 == 0) dl_c = $urandom_range(15);
      rot_c = $urandom_range(3);
      gain_c = $urandom_range(15);
      na_c = $urandom_range(15);
      dc_c = int'($urandom_range(255)) - 128;
      tick(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
           ($urandom_range(3) != 0) ? 1 : 0, ($urandom_range(9) == 0) ? 1 : 0);
    end

    // Ramp through the maximum delay across several pointer wraps, then shorten
    rot_c = 0; gain_c = 4; na_c = 0; dc_c = 0; dl_c = 15;
    for (int t = 0; t < 60; t++) tick(t, 0, 1, 0);
    dl_c = 4;
    for (int t = 60; t < 80; t++) tick(t, 0, 1, 0);

    freeze();

    // Reset with samples still in flight
    do_reset();

    // Noise statistics with zero input
    rot_c = 0; gain_c = 4; na_c = 5; dc_c = 0; dl_c = 0;
    for (int t = 0; t < 4098; t++) begin
      if (t == 2) collect = 1'b1;
      tick(0, 0, 1, 0);
    end
    collect = 1'b0;
    chk("noise_samples_in_range", st_bad, 0);
    chk("noise_mean_I_within_1", (st_sum_i <= st_cnt && st_sum_i >= -st_cnt) ? 1 : 0, 1);
    chk("noise_mean_Q_within_1", (st_sum_q <= st_cnt && st_sum_q >= -st_cnt) ? 1 : 0, 1);
    chk("noise_I_differs_from_Q", (st_diff > st_cnt / 2) ? 1 : 0, 1);

    // No noise gives exact zeros, then invalid input drains to zero outputs
    na_c = 0;
    repeat (20) tick(0, 0, 1, 0);
    repeat (4) tick(123, -45, 0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
